// File: rtl/vx_barrier_ctrl_if.sv
// Barrier arrival / release bundle between the warp-control execute path
// (master) and the per-core barrier responder (slave).
interface vx_barrier_ctrl_if #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NW_WIDTH     = $clog2(NUM_WARPS),
    parameter int NB_WIDTH     = $clog2(NUM_BARRIERS)
);
    logic                    bar_valid;
    logic                    bar_ready;
    logic [NW_WIDTH-1:0]     bar_wid;
    logic [NB_WIDTH-1:0]     bar_id;
    logic [NW_WIDTH-1:0]     bar_size_m1;
    logic [NUM_WARPS-1:0]    stalled_warps;
    logic                    release_valid;
    logic [NB_WIDTH-1:0]     release_id;
    logic [NUM_WARPS-1:0]    release_mask;
    logic                    err_dup;
    logic [NUM_BARRIERS-1:0] active_barriers;

    modport master (
        output bar_valid, bar_wid, bar_id, bar_size_m1,
        input  bar_ready, stalled_warps, release_valid, release_id,
               release_mask, err_dup, active_barriers
    );

    modport slave (
        input  bar_valid, bar_wid, bar_id, bar_size_m1,
        output bar_ready, stalled_warps, release_valid, release_id,
               release_mask, err_dup, active_barriers
    );
endinterface

// File: rtl/vx_barrier_ctrl.sv
// Per-core local barrier responder: counts arrivals per barrier ID, holds
// arriving warps stalled, and pulses a one-cycle release when the last
// participant arrives. One arrival is accepted per cycle.
module vx_barrier_ctrl #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NW_WIDTH     = $clog2(NUM_WARPS),
    parameter int NB_WIDTH     = $clog2(NUM_BARRIERS)
) (
    input  logic              clk,
    input  logic              reset,
    vx_barrier_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ARR_NONE,
        ARR_DUP,
        ARR_COMPLETE,
        ARR_ADVANCE
    } arr_kind_e;

    localparam logic [NW_WIDTH-1:0] CNT_ONE = {{(NW_WIDTH-1){1'b0}}, 1'b1};

    logic [NW_WIDTH-1:0]  cnt_q  [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  cnt_d  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] mask_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] mask_d [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  size_q [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]  size_d [NUM_BARRIERS];

    logic [NUM_WARPS-1:0] stalled_q, stalled_d;
    logic                 rel_valid_q, rel_valid_d;
    logic [NB_WIDTH-1:0]  rel_id_q, rel_id_d;
    logic [NUM_WARPS-1:0] rel_mask_q, rel_mask_d;
    logic                 err_dup_q, err_dup_d;

    arr_kind_e            kind;
    logic [NUM_WARPS-1:0] wid_oh;
    logic [NW_WIDTH-1:0]  eff_size;
    logic [NUM_WARPS-1:0] done_mask;

    // State register: barrier tables, stall vector and registered event outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
                cnt_q[b]  <= '0;
                mask_q[b] <= '0;
                size_q[b] <= '0;
            end
            stalled_q   <= '0;
            rel_valid_q <= 1'b0;
            rel_id_q    <= '0;
            rel_mask_q  <= '0;
            err_dup_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            size_q      <= size_d;
            stalled_q   <= stalled_d;
            rel_valid_q <= rel_valid_d;
            rel_id_q    <= rel_id_d;
            rel_mask_q  <= rel_mask_d;
            err_dup_q   <= err_dup_d;
        end
    end

    // Next state: classify the arrival (duplicate / completing / advancing) and update tables.
    always_comb begin
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        size_d      = size_q;
        stalled_d   = stalled_q;
        rel_valid_d = 1'b0;
        rel_id_d    = '0;
        rel_mask_d  = '0;
        err_dup_d   = 1'b0;

        wid_oh = '0;
        wid_oh[bus.bar_wid] = 1'b1;

        // An idle barrier takes its size from the request; a waiting one keeps the latched size.
        eff_size  = (mask_q[bus.bar_id] == '0) ? bus.bar_size_m1 : size_q[bus.bar_id];
        done_mask = mask_q[bus.bar_id] | wid_oh;

        kind = ARR_NONE;
        if (bus.bar_valid) begin
            if (mask_q[bus.bar_id][bus.bar_wid])
                kind = ARR_DUP;
            else if (cnt_q[bus.bar_id] == eff_size)
                kind = ARR_COMPLETE;
            else
                kind = ARR_ADVANCE;
        end

        case (kind)
            ARR_DUP: begin
                err_dup_d = 1'b1;
            end
            ARR_COMPLETE: begin
                rel_valid_d          = 1'b1;
                rel_id_d             = bus.bar_id;
                rel_mask_d           = done_mask;
                cnt_d[bus.bar_id]    = '0;
                mask_d[bus.bar_id]   = '0;
                size_d[bus.bar_id]   = '0;
                stalled_d            = stalled_q & ~done_mask;
            end
            ARR_ADVANCE: begin
                cnt_d[bus.bar_id]    = cnt_q[bus.bar_id] + CNT_ONE;
                mask_d[bus.bar_id]   = done_mask;
                stalled_d            = stalled_q | wid_oh;
                if (mask_q[bus.bar_id] == '0)
                    size_d[bus.bar_id] = bus.bar_size_m1;
            end
            default: ;
        endcase
    end

    // Outputs: registered events plus per-barrier activity derived from the masks.
    always_comb begin
        bus.bar_ready       = ~reset;
        bus.stalled_warps   = stalled_q;
        bus.release_valid   = rel_valid_q;
        bus.release_id      = rel_id_q;
        bus.release_mask    = rel_mask_q;
        bus.err_dup         = err_dup_q;
        bus.active_barriers = '0;
        for (int unsigned b = 0; b < NUM_BARRIERS; b++)
            bus.active_barriers[b] = |mask_q[b];
    end

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Self-checking bench for vx_barrier_ctrl: directed scenarios with literal
// expectations plus randomized arrivals checked against a queue-based model.
module tb_vx_barrier_ctrl;
    localparam int NW  = 4;
    localparam int NB  = 4;
    localparam int NWW = $clog2(NW);
    localparam int NBW = $clog2(NB);

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    vx_barrier_ctrl_if #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) bus ();

    vx_barrier_ctrl #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: per barrier, the list of waiting warps and the latched participant count.
    int unsigned    wq [NB][$];
    int unsigned    msz [NB];
    bit [NW-1:0]    m_stall;
    bit             e_rel;
    int unsigned    e_rid;
    bit [NW-1:0]    e_rmask;
    bit             e_dup;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int b = 0; b < NB; b++) begin
                    wq[b].delete();
                    msz[b] = 0;
                end
                m_stall = '0;
                e_rel = 0; e_rid = 0; e_rmask = '0; e_dup = 0;
            end else begin
                int unsigned b, w, eff;
                bit dup;
                e_rel = 0;
                e_dup = 0;
                if (bus.bar_valid) begin
                    b = int'(bus.bar_id);
                    w = int'(bus.bar_wid);
                    dup = 0;
                    for (int i = 0; i < wq[b].size(); i++)
                        if (wq[b][i] == w) dup = 1;
                    if (dup) begin
                        e_dup = 1;
                    end else begin
                        eff = (wq[b].size() == 0) ? int'(bus.bar_size_m1) : msz[b];
                        if (wq[b].size() == eff) begin
                            e_rel = 1;
                            e_rid = b;
                            e_rmask = '0;
                            e_rmask[w] = 1'b1;
                            for (int i = 0; i < wq[b].size(); i++)
                                e_rmask[wq[b][i]] = 1'b1;
                            m_stall = m_stall & ~e_rmask;
                            wq[b].delete();
                        end else begin
                            if (wq[b].size() == 0) msz[b] = int'(bus.bar_size_m1);
                            wq[b].push_back(w);
                            m_stall[w] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic [NB-1:0] e_act;
                for (int b = 0; b < NB; b++) e_act[b] = (wq[b].size() != 0);
                chk("bar_ready", 32'(bus.bar_ready), 32'(!reset));
                chk("stalled_warps", 32'(bus.stalled_warps), 32'(m_stall));
                chk("active_barriers", 32'(bus.active_barriers), 32'(e_act));
                chk("release_valid", 32'(bus.release_valid), 32'(e_rel));
                chk("err_dup", 32'(bus.err_dup), 32'(e_dup));
                if (e_rel) begin
                    chk("release_id", 32'(bus.release_id), e_rid);
                    chk("release_mask", 32'(bus.release_mask), 32'(e_rmask));
                end
            end
        end
    end

    task automatic drive(input bit v, input int unsigned w, input int unsigned id, input int unsigned s);
        bus.bar_valid   = v;
        bus.bar_wid     = NWW'(w);
        bus.bar_id      = NBW'(id);
        bus.bar_size_m1 = NWW'(s);
        @(posedge clk);
        #2;
    endtask

    task automatic arrive(input int unsigned w, input int unsigned id, input int unsigned s);
        drive(1'b1, w, id, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0);
    endtask

    initial begin
        bus.bar_valid = 1'b0; bus.bar_wid = '0; bus.bar_id = '0; bus.bar_size_m1 = '0;
        #1;
        chk("reset_ready", 32'(bus.bar_ready), 32'd0);
        chk("reset_stalled", 32'(bus.stalled_warps), 32'd0);
        chk("reset_release", 32'(bus.release_valid), 32'd0);
        chk("reset_active", 32'(bus.active_barriers), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        chk_en = 1'b1;
        idle(1);
        chk("ready_after_reset", 32'(bus.bar_ready), 32'd1);

        // Basic 4-warp barrier on id 1
        arrive(0, 1, 3); arrive(1, 1, 3); arrive(2, 1, 3);
        chk("basic_stalled", 32'(bus.stalled_warps), 32'h7);
        chk("basic_active", 32'(bus.active_barriers), 32'h2);
        arrive(3, 1, 3);
        chk("basic_rel_valid", 32'(bus.release_valid), 32'd1);
        chk("basic_rel_id", 32'(bus.release_id), 32'd1);
        chk("basic_rel_mask", 32'(bus.release_mask), 32'hF);
        chk("basic_stall_clr", 32'(bus.stalled_warps), 32'd0);

        // Back-to-back reuse of id 1 in the release cycle
        arrive(0, 1, 1);
        chk("reuse_stalled", 32'(bus.stalled_warps), 32'h1);
        chk("reuse_active", 32'(bus.active_barriers), 32'h2);
        arrive(1, 1, 0);
        chk("reuse_rel_mask", 32'(bus.release_mask), 32'h3);

        // Single-warp barrier
        arrive(2, 0, 0);
        chk("single_rel_valid", 32'(bus.release_valid), 32'd1);
        chk("single_rel_mask", 32'(bus.release_mask), 32'h4);
        chk("single_stalled", 32'(bus.stalled_warps), 32'd0);
        idle(1);

        // Duplicate and size mismatch
        arrive(1, 2, 1);
        arrive(1, 2, 1);
        chk("dup_err", 32'(bus.err_dup), 32'd1);
        chk("dup_no_rel", 32'(bus.release_valid), 32'd0);
        chk("dup_stalled", 32'(bus.stalled_warps), 32'h2);
        arrive(3, 2, 3);
        chk("dup_err_clear", 32'(bus.err_dup), 32'd0);
        chk("mismatch_rel_mask", 32'(bus.release_mask), 32'hA);
        chk("mismatch_rel_id", 32'(bus.release_id), 32'd2);

        // Interleaved barriers 0 and 3
        arrive(0, 0, 1); arrive(1, 3, 1);
        chk("inter_active", 32'(bus.active_barriers), 32'h9);
        arrive(2, 0, 1);
        chk("inter_rel0_id", 32'(bus.release_id), 32'd0);
        chk("inter_rel0_mask", 32'(bus.release_mask), 32'h5);
        chk("inter_active2", 32'(bus.active_barriers), 32'h8);
        arrive(3, 3, 1);
        chk("inter_rel3_id", 32'(bus.release_id), 32'd3);
        chk("inter_rel3_mask", 32'(bus.release_mask), 32'hA);
        idle(1);

        // Reset mid-operation with three waiting warps
        arrive(0, 2, 3); arrive(1, 2, 3); arrive(2, 2, 3);
        idle(1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus.bar_ready), 32'd0);
        chk("midrst_stalled", 32'(bus.stalled_warps), 32'd0);
        chk("midrst_active", 32'(bus.active_barriers), 32'd0);
        chk("midrst_release", 32'(bus.release_valid), 32'd0);
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b0;
        idle(1);
        arrive(0, 2, 1); arrive(1, 2, 1);
        chk("postrst_rel_mask", 32'(bus.release_mask), 32'h3);
        idle(1);

        // Randomized arrivals, including protocol violations and duplicates
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, NW - 1),
                  $urandom_range(0, NB - 1), $urandom_range(0, NW - 1));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
